secuenciador_filtro_bandas: RTL and testbench
=============================================

// Module: secuenciador_filtro_bandas
// PURPOSE
//  Drives the control side of the low-pass filter datapath. The datapath has
//  one shared multiplier/adder set and three per-band state register pairs.
//  For each input sample this block runs the datapath once per band (altas,
//  medias, bajas), captures the filter output and commits each band's state.
//  It then presents the three band results on a valid/ready output.
// PARAMETERS
//  Width        22  sample/result word width, signed fixed point (same format as filter)
//  SettleCycles 2   cycles Sel_Muxes/uk are held before capture (combinational settle); >=1
// PORTS
//  clk150kHz    in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  sample_in    in   Width  signed input sample
//  sample_valid in   1      sample_in valid
//  sample_ready out  1      block can accept a sample (high only in IDLE)
//  Sel_Muxes    out  2      band select to filter: 00 altas, 01 medias, 10 bajas, 11 idle
//  uk           out  Width  sample presented to filter input
//  enable1      out  1      commit strobe, altas state registers
//  enable2      out  1      commit strobe, medias state registers
//  enable3      out  1      commit strobe, bajas state registers
//  Conex_Bajos  in   Width  filter output for the currently selected band
//  y_altas      out  Width  captured band-00 result
//  y_medias     out  Width  captured band-01 result
//  y_bajas      out  Width  captured band-10 result
//  out_valid    out  1      y_* hold a complete result set
//  out_ready    in   1      consumer accepts result set
//  busy         out  1      high in any state except IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, uk=0, y_*=0, Sel_Muxes=2'b11, enables=0,
//    out_valid=0, busy=0, sample_ready=1 once reset is released.
//    Enables drop immediately, so no partial commit occurs.
//  - FSM: IDLE -> SETTLE -> COMMIT -> (SETTLE next band | DONE) -> IDLE.
//  - IDLE: sample_ready=1. On sample_valid&&sample_ready edge: uk<=sample_in,
//    band<=0, cnt<=0, go SETTLE. sample_valid without ready is ignored; the
//    source holds it.
//  - SETTLE: Sel_Muxes=band code, uk held. cnt increments. At cnt==SettleCycles-1, go COMMIT.
//  - COMMIT (exactly 1 cycle): Sel_Muxes unchanged. The enable for the current band is 1
//    (one-hot; others 0). At the closing edge, y_<band> <= Conex_Bajos.
//    Band 2 goes to DONE; otherwise band++, cnt<=0, SETTLE.
//  - Enables are registered outputs, high only in COMMIT. An enable is never high
//    while Sel_Muxes differs from its band.
//  - DONE: out_valid=1, Sel_Muxes=11, y_* stable. On out_ready edge go IDLE,
//    out_valid falls. out_ready outside DONE is ignored.
//  - Latency: out_valid rises 3*(SettleCycles+1) edges after the accepting edge
//    (9 at default).
//    Minimum sample period with out_ready=1 is 3*(SettleCycles+1)+2 cycles (11).
//  - No arithmetic on data: Conex_Bajos is copied bit-exact into y_*.
//    uk equals sample_in bit-exact.
//  - Reset mid-operation: abort to IDLE with reset values. y_* are cleared.
//    Band state already committed stays in the filter.
// TESTING (bench uses stub filter: Conex_Bajos = uk + 16*Sel_Muxes, combinational)
//  1 reset=0 mid-activity -> all outputs 0, Sel_Muxes=11; release -> sample_ready=1 next cycle
//  2 sample_in=1000, valid 1 cycle -> y_altas=1000, y_medias=1016, y_bajas=1032,
//    out_valid at edge 9
//  3 same run -> enable1, enable2, enable3 pulse once each, in order, each 1 cycle wide.
//    Sel_Muxes is 00/01/10 for 3 cycles ending with each pulse.
//  4 out_ready=0 for 20 cycles -> out_valid and y_* held, sample_ready=0 throughout.
//    A sample_valid=1 pulse in this window is not accepted.
//  5 reset asserted during band-01 SETTLE -> enable2/enable3 never pulse, y_*=0,
//    IDLE after release
//  6 sample_valid and out_ready held 1, samples -5, 7, -9 -> one accept every 11 cycles.
//    y_altas sequence is -5, 7, -9.

Source files
------------

// File: rtl/secuenciador_filtro_bandas_if.sv
// Bundle of the sample, result and filter-control signals around the band sequencer.
//   slave  : the sequencer side (takes samples and the filter output, drives the filter controls and the results)
//   master : the environment side (the sample source, the result consumer and the filter datapath)
// Port summary (slave view):
//   in  sample_in, sample_valid   signed input sample and its qualifier
//   out sample_ready              sequencer can take a sample
//   out Sel_Muxes, uk             band select and sample presented to the filter
//   out enable1/2/3               per-band state commit strobes
//   in  Conex_Bajos               filter output for the selected band
//   out y_altas/y_medias/y_bajas  captured band results
//   out out_valid                 result set is complete
//   in  out_ready                 consumer takes the result set
//   out busy                      a sample is being processed or held
`timescale 1ns/1ps
interface secuenciador_filtro_bandas_if #(
  parameter int Width = 22
);
  logic signed [Width-1:0] sample_in;
  logic                    sample_valid;
  logic                    sample_ready;
  logic [1:0]              Sel_Muxes;
  logic signed [Width-1:0] uk;
  logic                    enable1;
  logic                    enable2;
  logic                    enable3;
  logic signed [Width-1:0] Conex_Bajos;
  logic signed [Width-1:0] y_altas;
  logic signed [Width-1:0] y_medias;
  logic signed [Width-1:0] y_bajas;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  modport slave (
    input  sample_in, sample_valid, Conex_Bajos, out_ready,
    output sample_ready, Sel_Muxes, uk, enable1, enable2, enable3,
           y_altas, y_medias, y_bajas, out_valid, busy
  );

  modport master (
    output sample_in, sample_valid, Conex_Bajos, out_ready,
    input  sample_ready, Sel_Muxes, uk, enable1, enable2, enable3,
           y_altas, y_medias, y_bajas, out_valid, busy
  );
endinterface

// File: rtl/secuenciador_filtro_bandas.sv
// Control sequencer for the shared low-pass filter datapath.
// Each accepted sample is run through the filter once per band (altas, medias,
// bajas): the band is selected and held for SettleCycles cycles so the
// combinational datapath settles, then one commit cycle strobes that band's
// state-register enable and captures the filter output. After the third band
// the three results are offered on a valid/ready handshake.
// Ports:
//   clk150kHz  system clock, rising edge
//   reset      asynchronous active-low reset
//   bus        secuenciador_filtro_bandas_if.slave (samples, filter controls, results)
// All outputs are registered; they are computed from the next state so an
// enable can never be high while Sel_Muxes shows a different band.
`timescale 1ns/1ps
module secuenciador_filtro_bandas #(
  parameter int Width        = 22,
  parameter int SettleCycles = 2
) (
  input logic                         clk150kHz,
  input logic                         reset,
  secuenciador_filtro_bandas_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, DONE} state_t;

  // Band codes double as the Sel_Muxes encoding.
  typedef enum logic [1:0] {
    BAND_ALTAS  = 2'b00,
    BAND_MEDIAS = 2'b01,
    BAND_BAJAS  = 2'b10
  } band_t;

  localparam logic [1:0]      SelIdle = 2'b11;
  localparam int              CntW    = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SettleCycles - 1);

  state_t                  state_q, state_d;
  band_t                   band_q, band_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic signed [Width-1:0] uk_q;
  logic signed [Width-1:0] y_altas_q, y_medias_q, y_bajas_q;
  logic [1:0]              sel_q;
  logic [2:0]              en_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    ready_q;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    band_d  = band_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.sample_valid && ready_q) begin
          state_d = SETTLE;
          band_d  = BAND_ALTAS;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (band_q == BAND_BAJAS) begin
          state_d = DONE;
        end else begin
          state_d = SETTLE;
          band_d  = band_t'(band_q + 2'd1);
          cnt_d   = '0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk150kHz or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      band_q      <= BAND_ALTAS;
      cnt_q       <= '0;
      uk_q        <= '0;
      y_altas_q   <= '0;
      y_medias_q  <= '0;
      y_bajas_q   <= '0;
      sel_q       <= SelIdle;
      en_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      band_q  <= band_d;
      cnt_q   <= cnt_d;

      if (state_q == IDLE && state_d == SETTLE) begin
        uk_q <= bus.sample_in;
      end

      // The closing edge of a commit cycle captures the selected band's result.
      if (state_q == COMMIT) begin
        case (band_q)
          BAND_ALTAS:  y_altas_q  <= bus.Conex_Bajos;
          BAND_MEDIAS: y_medias_q <= bus.Conex_Bajos;
          default:     y_bajas_q  <= bus.Conex_Bajos;
        endcase
      end

      sel_q       <= (state_d == SETTLE || state_d == COMMIT) ? band_d : SelIdle;
      en_q        <= (state_d == COMMIT) ? (3'b001 << band_d) : 3'b000;
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      ready_q     <= (state_d == IDLE);
    end
  end

  assign bus.sample_ready = ready_q;
  assign bus.Sel_Muxes    = sel_q;
  assign bus.uk           = uk_q;
  assign bus.enable1      = en_q[0];
  assign bus.enable2      = en_q[1];
  assign bus.enable3      = en_q[2];
  assign bus.y_altas      = y_altas_q;
  assign bus.y_medias     = y_medias_q;
  assign bus.y_bajas      = y_bajas_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_secuenciador_filtro_bandas.sv
// Testbench for secuenciador_filtro_bandas with a stub filter
// (Conex_Bajos = uk + 16*Sel_Muxes). A transaction-level model tracks how many
// edges have passed since a sample was accepted and derives every output from
// that count; a compare process checks the DUT against it on each falling edge.
// Directed sequences pin the model with hand-computed values, then random
// traffic (including random resets) runs against the model.
`timescale 1ns/1ps
module tb_secuenciador_filtro_bandas;

  localparam int W   = 22;
  localparam int SC  = 2;
  localparam int P   = SC + 1;   // cycles per band
  localparam int LAT = 3 * P;    // edges from accept to out_valid

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  secuenciador_filtro_bandas_if #(.Width(W)) bus ();

  secuenciador_filtro_bandas #(.Width(W), .SettleCycles(SC)) u_dut (
    .clk150kHz (clk),
    .reset     (rst_n),
    .bus       (bus)
  );

  // Stub filter datapath.
  assign bus.Conex_Bajos = bus.uk + {{(W-6){1'b0}}, bus.Sel_Muxes, 4'b0000};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // m_t < 0: waiting for a sample; 0..LAT-1: edges since accept; LAT: result held.
  int           m_t   = -1;
  bit           m_rdy = 1'b0;
  logic [W-1:0] m_uk  = '0;
  logic [W-1:0] m_y [3] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t   <= -1;
      m_rdy <= 1'b0;
      m_uk  <= '0;
      m_y   <= '{default: '0};
    end else if (m_t < 0) begin
      if (m_rdy && bus.sample_valid) begin
        m_t   <= 0;
        m_uk  <= bus.sample_in;
        m_rdy <= 1'b0;
      end else begin
        m_rdy <= 1'b1;
      end
    end else if (m_t < LAT) begin
      m_t <= m_t + 1;
      if ((m_t + 1) % P == 0)
        m_y[(m_t + 1) / P - 1] <= m_uk + W'(16 * ((m_t + 1) / P - 1));
    end else if (bus.out_ready) begin
      m_t   <= -1;
      m_rdy <= 1'b1;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    bit         run;
    logic [1:0] s_e;
    logic [2:0] en_e;
    if (cmp_en) begin
      run  = (m_t >= 0) && (m_t < LAT);
      s_e  = run ? 2'(m_t / P) : 2'b11;
      en_e = (run && (m_t % P == SC)) ? 3'(1 << (m_t / P)) : 3'b000;
      check("sample_ready", W'(bus.sample_ready), W'((m_t < 0) && m_rdy));
      check("busy",         W'(bus.busy),         W'(m_t >= 0));
      check("out_valid",    W'(bus.out_valid),    W'(m_t == LAT));
      check("sel",          W'(bus.Sel_Muxes),    W'(s_e));
      check("enables",      W'({bus.enable3, bus.enable2, bus.enable1}), W'(en_e));
      check("uk",           bus.uk,               m_uk);
      check("y_altas",      bus.y_altas,          m_y[0]);
      check("y_medias",     bus.y_medias,         m_y[1]);
      check("y_bajas",      bus.y_bajas,          m_y[2]);
    end
  end

  // Watch for any band-01/10 commit during the mid-run reset sequence.
  bit watch23 = 1'b0;
  bit seen23  = 1'b0;
  always @(negedge clk)
    if (watch23 && (bus.enable2 || bus.enable3)) seen23 <= 1'b1;

  // Collect y_altas for each completed result set.
  bit cap_en = 1'b0;
  logic [W-1:0] yq[$];
  always @(negedge clk)
    if (cap_en && bus.out_valid) yq.push_back(bus.y_altas);

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present a sample and return (2 ns after the accepting edge) once taken.
  task automatic offer(input logic [W-1:0] s, input bit drop_valid, output int unsigned acc);
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.sample_ready) begin
        @(posedge clk);
        #2;
        acc = cyc;
        if (drop_valid) bus.sample_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", W'(0), W'(1));
    acc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a0, a1, a2;
    logic [1:0] exp_sel [9];
    logic [2:0] exp_en  [9];
    exp_sel = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    exp_en  = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd4};

    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.out_ready    = 1'b0;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;

    // Reset state and release.
    repeat (3) step();
    check("rst_sel",   W'(bus.Sel_Muxes),    W'(2'b11));
    check("rst_ready", W'(bus.sample_ready), W'(0));
    rst_n = 1'b1;
    check("ready_at_release", W'(bus.sample_ready), W'(0));
    step();
    check("ready_after_release", W'(bus.sample_ready), W'(1));

    // Single sample 1000: band sequence, strobes, results, latency.
    step();
    offer(W'(1000), 1'b1, a0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("seq_sel", W'(bus.Sel_Muxes), W'(exp_sel[k]));
      check("seq_en",  W'({bus.enable3, bus.enable2, bus.enable1}), W'(exp_en[k]));
      check("seq_ov_low", W'(bus.out_valid), W'(0));
    end
    @(negedge clk);
    check("ov_edge9",  W'(bus.out_valid), W'(1));
    check("lat_edges", W'(cyc - a0),      W'(9));
    check("y_altas_1000",  bus.y_altas,  W'(1000));
    check("y_medias_1016", bus.y_medias, W'(1016));
    check("y_bajas_1032",  bus.y_bajas,  W'(1032));

    // Backpressure: 20 cycles of out_ready=0 with a stray sample_valid pulse.
    for (int i = 0; i < 20; i++) begin
      step();
      bus.sample_valid = (i == 5);
      bus.sample_in    = (i == 5) ? W'(123) : W'(1000);
      @(negedge clk);
      check("hold_ov",    W'(bus.out_valid),    W'(1));
      check("hold_ready", W'(bus.sample_ready), W'(0));
      check("hold_y",     bus.y_altas,          W'(1000));
    end
    step();
    bus.sample_valid = 1'b0;
    check("hold_uk", bus.uk, W'(1000));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("release_ov",    W'(bus.out_valid),    W'(0));
    check("release_ready", W'(bus.sample_ready), W'(1));

    // Reset in the middle of a run.
    step();
    offer(W'(77), 1'b1, a0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel",  W'(bus.Sel_Muxes), W'(2'b11));
    check("mid_rst_en",   W'({bus.enable3, bus.enable2, bus.enable1}), W'(0));
    check("mid_rst_uk",   bus.uk,      W'(0));
    check("mid_rst_y",    bus.y_altas, W'(0));
    check("mid_rst_busy", W'(bus.busy), W'(0));
    repeat (2) step();
    rst_n = 1'b1;
    check("mid_rel_ready0", W'(bus.sample_ready), W'(0));
    step();
    check("mid_rel_ready1", W'(bus.sample_ready), W'(1));

    // Reset during band-01 settle: no medias/bajas commit, results cleared.
    step();
    seen23  = 1'b0;
    watch23 = 1'b1;
    offer(W'(500), 1'b1, a0);
    repeat (3) step();
    check("b1_y_altas_500", bus.y_altas,      W'(500));
    check("b1_sel",         W'(bus.Sel_Muxes), W'(1));
    step();
    rst_n = 1'b0;
    #1;
    check("b1_rst_y_altas", bus.y_altas, W'(0));
    check("b1_rst_en",      W'({bus.enable3, bus.enable2, bus.enable1}), W'(0));
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();
    watch23 = 1'b0;
    check("b1_no_en23", W'(seen23),           W'(0));
    check("b1_idle",    W'(bus.busy),         W'(0));
    check("b1_ready",   W'(bus.sample_ready), W'(1));
    check("b1_y_bajas", bus.y_bajas,          W'(0));

    // Back-to-back samples with valid and out_ready held high.
    bus.out_ready = 1'b1;
    step();
    yq.delete();
    cap_en = 1'b1;
    offer(W'(-5), 1'b0, a0);
    offer(W'(7),  1'b0, a1);
    offer(W'(-9), 1'b1, a2);
    repeat (14) step();
    cap_en = 1'b0;
    check("period_1", W'(a1 - a0), W'(11));
    check("period_2", W'(a2 - a1), W'(11));
    check("yq_size",  W'(yq.size()), W'(3));
    if (yq.size() >= 3) begin
      check("yq_0", yq[0], W'(-5));
      check("yq_1", yq[1], W'(7));
      check("yq_2", yq[2], W'(-9));
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n            = ($urandom_range(0, 299) != 0);
      bus.sample_valid = ($urandom_range(0, 3) != 0);
      bus.sample_in    = W'($urandom);
      bus.out_ready    = ($urandom_range(0, 2) != 0);
    end
    step();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
